// File: rtl/ads131_frame_capture.sv
// DRDY-triggered SPI mode-1 frame reader for the ADS131A0x with a single-entry valid/ready buffer.
// Define ADS131_CRC_EN to receive a trailing CRC word and report mismatches on crc_err.
module ads131_frame_capture #(
    parameter int CLK_DIV   = 6,
    parameter int WORD_BITS = 24,
    parameter int NUM_CH    = 4,
    parameter int CS_GUARD  = 8
) (
    input  logic                   system_clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   drdy_n,
    output logic                   spi_sclk,
    output logic                   spi_cs_n,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    input  logic [WORD_BITS-1:0]   cmd_word,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [15:0]            status_word,
    output logic [32*NUM_CH-1:0]   ch_data,
    output logic                   busy,
    output logic                   overrun,
`ifdef ADS131_CRC_EN
    output logic                   crc_err,
`endif
    output logic [7:0]             overrun_count
);

`ifdef ADS131_CRC_EN
    localparam int NUM_WORDS = NUM_CH + 2;
`else
    localparam int NUM_WORDS = NUM_CH + 1;
`endif
    localparam int CNT_MAX = (CLK_DIV > CS_GUARD) ? CLK_DIV : CS_GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(WORD_BITS);
    localparam int WIDX_W  = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_STORE, S_GUARD
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 drdy_s1, drdy_s2, drdy_d;
    logic                 start;
    logic                 sclk_q;
    logic [WORD_BITS-1:0] mosi_sr;
    logic [WORD_BITS-1:0] miso_sr;
    logic [WORD_BITS-1:0] word_next;
    logic [BIT_W-1:0]     bit_idx;
    logic [WIDX_W-1:0]    word_idx;
    logic                 div_end, guard_end, first_bit, last_bit, word_end;
    logic                 sclk_rise, sclk_fall;
    logic [15:0]          stage_status;
    logic [32*NUM_CH-1:0] stage_ch;
    logic                 load, drop;

    // drdy_d holds the previous synchronized level so a 1->0 transition is seen exactly once.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            drdy_s1 <= 1'b1;
            drdy_s2 <= 1'b1;
            drdy_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
            drdy_s1 <= drdy_n;
            drdy_s2 <= drdy_s1;
            drdy_d  <= drdy_s2;
        end
    end

    assign start     = (state == S_IDLE) && enable && drdy_d && !drdy_s2;
    assign div_end   = (cnt == CNT_W'(CLK_DIV - 1));
    assign guard_end = (cnt == CNT_W'(CS_GUARD - 1));
    assign first_bit = (word_idx == '0) && (bit_idx == '0);
    assign last_bit  = (word_idx == WIDX_W'(NUM_WORDS - 1)) && (bit_idx == BIT_W'(WORD_BITS - 1));
    assign sclk_rise = (state == S_SHIFT) && div_end && !sclk_q;
    assign sclk_fall = (state == S_SHIFT) && div_end && sclk_q;
    assign word_end  = sclk_fall && (bit_idx == BIT_W'(WORD_BITS - 1));
    assign word_next = {miso_sr[WORD_BITS-2:0], spi_miso};

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE:  if (start)                 state_next = S_SETUP;
            S_SETUP: if (div_end)               state_next = S_SHIFT;
            S_SHIFT: if (sclk_fall && last_bit) state_next = S_HOLD;
            S_HOLD:  if (div_end)               state_next = S_STORE;
            S_STORE:                            state_next = S_GUARD;
            S_GUARD: if (guard_end)             state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        spi_cs_n = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));
    end

    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_sr[WORD_BITS-1];

    // Phase counter restarts on every state change and on every SCLK half-period boundary.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n)                                      cnt <= '0;
        else if (state == S_IDLE || state_next != state)   cnt <= '0;
        else if (state == S_SHIFT && div_end)              cnt <= '0;
        else                                               cnt <= cnt + CNT_W'(1);
    end

    // The first MOSI bit is already on the line from SETUP, so the first rising edge does not shift.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q   <= 1'b0;
            mosi_sr  <= '0;
            miso_sr  <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
        end else begin
            if (start) begin
                mosi_sr  <= cmd_word;
                bit_idx  <= '0;
                word_idx <= '0;
            end
            if (sclk_rise) begin
                sclk_q <= 1'b1;
                if (!first_bit) mosi_sr <= {mosi_sr[WORD_BITS-2:0], 1'b0};
            end
            if (sclk_fall) begin
                sclk_q  <= 1'b0;
                miso_sr <= word_next;
                if (bit_idx == BIT_W'(WORD_BITS - 1)) begin
                    bit_idx  <= '0;
                    word_idx <= word_idx + WIDX_W'(1);
                end else begin
                    bit_idx <= bit_idx + BIT_W'(1);
                end
            end
        end
    end

    // NOTE: staging registers are few enough to reset, which keeps a truncated frame's leftovers deterministic.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_status <= '0;
            stage_ch     <= '0;
        end else if (word_end) begin
            if (word_idx == '0) stage_status <= word_next[WORD_BITS-1 -: 16];
            for (int k = 0; k < NUM_CH; k++) begin
                if (word_idx == WIDX_W'(k + 1)) stage_ch[32*k +: 32] <= 32'($signed(word_next));
            end
        end
    end

`ifdef ADS131_CRC_EN
    logic [15:0] crc_calc, rx_crc;

    // CRC-16-CCITT runs over every bit before the trailing CRC word.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_calc <= 16'hFFFF;
            rx_crc   <= '0;
        end else begin
            if (start)
                crc_calc <= 16'hFFFF;
            else if (sclk_fall && word_idx != WIDX_W'(NUM_WORDS - 1))
                crc_calc <= {crc_calc[14:0], 1'b0} ^ ((crc_calc[15] ^ spi_miso) ? 16'h1021 : 16'h0000);
            if (word_end && word_idx == WIDX_W'(NUM_WORDS - 1))
                rx_crc <= word_next[WORD_BITS-1 -: 16];
        end
    end
`endif

    assign load = (state == S_STORE) && (!frame_valid || frame_ready);
    assign drop = (state == S_STORE) && frame_valid && !frame_ready;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid   <= 1'b0;
            status_word   <= '0;
            ch_data       <= '0;
            overrun       <= 1'b0;
            overrun_count <= '0;
`ifdef ADS131_CRC_EN
            crc_err       <= 1'b0;
`endif
        end else begin
            overrun <= drop;
            if (load) begin
                frame_valid <= 1'b1;
                status_word <= stage_status;
                ch_data     <= stage_ch;
`ifdef ADS131_CRC_EN
                crc_err     <= (crc_calc != rx_crc);
`endif
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (drop && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_ads131_frame_capture.sv
// Self-checking bench for ads131_frame_capture: a MISO device model, a MOSI/SCLK monitor and
// a word-level reference model; a second small instance exercises overrun saturation.
`timescale 1ns/1ps
module tb_ads131_frame_capture;

    localparam int WB  = 24;
    localparam int NCH = 4;
`ifdef ADS131_CRC_EN
    localparam int NW = NCH + 2;
`else
    localparam int NW = NCH + 1;
`endif
    localparam int L = NW * WB;

    typedef logic [NCH:0][WB-1:0] words_t;
    typedef logic [NCH-1:0][31:0] chs_t;

    typedef struct {
        string         name;
        logic [WB-1:0] cmd;
        words_t        w;
        logic [15:0]   exp_status;
        chs_t          exp_ch;
    } vec_t;

    logic                 system_clock;
    logic                 reset_n;
    logic                 enable;
    logic                 drdy_n;
    logic                 spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [WB-1:0]        cmd_word;
    logic                 frame_valid, frame_ready;
    logic [15:0]          status_word;
    logic [32*NCH-1:0]    ch_data;
    logic                 busy, overrun;
    logic [7:0]           overrun_count;
`ifdef ADS131_CRC_EN
    logic                 crc_err;
`endif

    logic                 s_drdy_n, s_sclk, s_cs_n, s_mosi, s_miso;
    logic                 s_valid, s_busy, s_overrun;
    logic [15:0]          s_status;
    logic [31:0]          s_ch;
    logic [7:0]           s_overrun_count;
`ifdef ADS131_CRC_EN
    logic                 s_crc_err;
`endif

    ads131_frame_capture u_dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .drdy_n       (drdy_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .cmd_word     (cmd_word),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .status_word  (status_word),
        .ch_data      (ch_data),
        .busy         (busy),
        .overrun      (overrun),
`ifdef ADS131_CRC_EN
        .crc_err      (crc_err),
`endif
        .overrun_count(overrun_count)
    );

    ads131_frame_capture #(.CLK_DIV(1), .WORD_BITS(16), .NUM_CH(1), .CS_GUARD(2)) u_sat (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .enable       (1'b1),
        .drdy_n       (s_drdy_n),
        .spi_sclk     (s_sclk),
        .spi_cs_n     (s_cs_n),
        .spi_mosi     (s_mosi),
        .spi_miso     (s_miso),
        .cmd_word     (16'h0000),
        .frame_valid  (s_valid),
        .frame_ready  (1'b0),
        .status_word  (s_status),
        .ch_data      (s_ch),
        .busy         (s_busy),
        .overrun      (s_overrun),
`ifdef ADS131_CRC_EN
        .crc_err      (s_crc_err),
`endif
        .overrun_count(s_overrun_count)
    );

    initial system_clock = 1'b0;
    always #10 system_clock = ~system_clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [L-1:0] tx_bits = '0;
    logic [L-1:0] mosi_bits;
    int           miso_idx = 0;
    int           sclk_rises, sclk_bad, mosi_n, cs_falls, ovr_pulses, busy_seen;
    logic         first_rise_mosi, setup_mosi;

    // Device model: drives MISO on each SCLK rise, so the DUT's falling-edge sample sees a settled bit.
    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            sclk_rises++;
            if (sclk_rises == 1) first_rise_mosi = spi_mosi;
            spi_miso = (miso_idx < L) ? tx_bits[L-1-miso_idx] : 1'b0;
            miso_idx++;
        end else begin
            sclk_bad++;
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n) begin
            mosi_bits = {mosi_bits[L-2:0], spi_mosi};
            mosi_n++;
        end
    end

    always @(negedge spi_cs_n) begin
        miso_idx = 0;
        cs_falls++;
    end

    always @(negedge system_clock) begin
        if (overrun) ovr_pulses++;
        if (busy)    busy_seen++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [WB-1:0] w);
        int v;
        v = int'({8'h00, w});
        if (v >= 8388608) v = v - 16777216;
        return 32'(v);
    endfunction

    task automatic model(input words_t w, output logic [15:0] st, output chs_t ch);
        st = w[0][WB-1 -: 16];
        for (int k = 0; k < NCH; k++) ch[k] = sext(w[k+1]);
    endtask

    function automatic logic [L-1:0] build_tx(input words_t w);
        logic [L-1:0] t;
        t = '0;
        for (int i = 0; i <= NCH; i++) t[L-1-i*WB -: WB] = w[i];
        return t;
    endfunction

`ifdef ADS131_CRC_EN
    function automatic logic [15:0] crc16(input logic [L-1:0] bits);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < (NCH + 1) * WB; i++) begin
            fb = c[15] ^ bits[L-1-i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    task automatic wait_busy(input logic want, input int budget, input string what);
        int n;
        n = 0;
        while (busy !== want && n < budget) begin
            @(negedge system_clock);
            n++;
        end
        if (busy !== want) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout %s: busy=%0b after %0d cycles, expected %0b", what, busy, n, want);
        end
    endtask

    task automatic start_frame(input logic [WB-1:0] cmd, input logic [L-1:0] bits);
        tx_bits    = bits;
        cmd_word   = cmd;
        sclk_rises = 0;
        sclk_bad   = 0;
        mosi_n     = 0;
        mosi_bits  = '0;
        cs_falls   = 0;
        @(negedge system_clock) drdy_n = 1'b0;
        wait_busy(1'b1, 20, "frame_start");
        setup_mosi = spi_mosi;
    endtask

    task automatic finish_frame();
        wait_busy(1'b0, 4000, "frame_end");
        @(negedge system_clock) drdy_n = 1'b1;
        repeat (4) @(negedge system_clock);
    endtask

    task automatic check_bus(input string name, input logic [WB-1:0] cmd);
        check({name, "_sclk_rises"}, sclk_rises, L);
        check({name, "_sclk_cs_high"}, sclk_bad, 0);
        check({name, "_mosi_bits"}, mosi_n, L);
        check({name, "_mosi_cmd"}, 32'(mosi_bits[L-1 -: WB]), 32'(cmd));
        check({name, "_mosi_tail_nonzero"}, 32'(mosi_bits[L-WB-1:0] != '0), 0);
        check({name, "_mosi_setup"}, 32'(setup_mosi), 32'(cmd[WB-1]));
        check({name, "_mosi_first_rise"}, 32'(first_rise_mosi), 32'(cmd[WB-1]));
        check({name, "_cs_frames"}, cs_falls, 1);
    endtask

    task automatic check_data(input string name, input logic [15:0] st, input chs_t ch, input logic exp_crc_err);
        check({name, "_valid"}, 32'(frame_valid), 1);
        check({name, "_status"}, 32'(status_word), 32'(st));
        for (int k = 0; k < NCH; k++)
            check($sformatf("%s_ch%0d", name, k), ch_data[32*k +: 32], ch[k]);
`ifdef ADS131_CRC_EN
        check({name, "_crc_err"}, 32'(crc_err), 32'(exp_crc_err));
`else
        if (exp_crc_err) $display("note: crc_err expectation ignored without CRC");
`endif
    endtask

    task automatic consume(input string name);
        @(negedge system_clock) frame_ready = 1'b1;
        @(negedge system_clock) frame_ready = 1'b0;
        @(negedge system_clock);
        check({name, "_consumed"}, 32'(frame_valid), 0);
    endtask

    function automatic logic [L-1:0] frame_bits(input words_t w);
        logic [L-1:0] t;
        t = build_tx(w);
`ifdef ADS131_CRC_EN
        t[WB-1:0] = {crc16(t), 8'h00};
`endif
        return t;
    endfunction

    task automatic random_words(output words_t w);
        for (int i = 0; i <= NCH; i++) w[i] = WB'($urandom);
    endtask

    vec_t         vecs[3];
    words_t       wa, wb;
    logic [15:0]  st_a, st_b;
    chs_t         ch_a, ch_b;
    logic [WB-1:0] cmd_r;
    int           n, sat_timeouts;

    initial begin
        vecs[0].name = "t1_limits";
        vecs[0].cmd  = 24'h000000;
        vecs[0].w[0] = 24'h2230A5; vecs[0].w[1] = 24'h7FFFFF; vecs[0].w[2] = 24'h800000;
        vecs[0].w[3] = 24'h000001; vecs[0].w[4] = 24'hFFFFFF;
        vecs[0].exp_status = 16'h2230;
        vecs[0].exp_ch[0] = 32'h007FFFFF; vecs[0].exp_ch[1] = 32'hFF800000;
        vecs[0].exp_ch[2] = 32'h00000001; vecs[0].exp_ch[3] = 32'hFFFFFFFF;

        vecs[1].name = "t2_cmd";
        vecs[1].cmd  = 24'h001100;
        vecs[1].w[0] = 24'h123456; vecs[1].w[1] = 24'h000000; vecs[1].w[2] = 24'h400000;
        vecs[1].w[3] = 24'hABCDEF; vecs[1].w[4] = 24'h00FF00;
        vecs[1].exp_status = 16'h1234;
        vecs[1].exp_ch[0] = 32'h00000000; vecs[1].exp_ch[1] = 32'h00400000;
        vecs[1].exp_ch[2] = 32'hFFABCDEF; vecs[1].exp_ch[3] = 32'h0000FF00;

        vecs[2].name = "vec_mixed";
        vecs[2].cmd  = 24'h800001;
        vecs[2].w[0] = 24'hFFFFFF; vecs[2].w[1] = 24'h7FFFFE; vecs[2].w[2] = 24'h800001;
        vecs[2].w[3] = 24'h555555; vecs[2].w[4] = 24'hAAAAAA;
        vecs[2].exp_status = 16'hFFFF;
        vecs[2].exp_ch[0] = 32'h007FFFFE; vecs[2].exp_ch[1] = 32'hFF800001;
        vecs[2].exp_ch[2] = 32'h00555555; vecs[2].exp_ch[3] = 32'hFFAAAAAA;

        reset_n = 1'b0; enable = 1'b1; drdy_n = 1'b1; spi_miso = 1'b0;
        cmd_word = '0; frame_ready = 1'b0; s_drdy_n = 1'b1; s_miso = 1'b0;
        sclk_rises = 0; sclk_bad = 0; mosi_n = 0; cs_falls = 0; ovr_pulses = 0; busy_seen = 0;
        mosi_bits = '0; first_rise_mosi = 1'b0; setup_mosi = 1'b0;
        #35;
        check("rst_cs_n", 32'(spi_cs_n), 1);
        check("rst_sclk", 32'(spi_sclk), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_status", 32'(status_word), 0);
        check("rst_ch_nonzero", 32'(ch_data != '0), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_overrun_count", 32'(overrun_count), 0);
        @(negedge system_clock) reset_n = 1'b1;
        repeat (4) @(negedge system_clock);

        for (int i = 0; i < 3; i++) begin
            start_frame(vecs[i].cmd, frame_bits(vecs[i].w));
            finish_frame();
            check_bus(vecs[i].name, vecs[i].cmd);
            check_data(vecs[i].name, vecs[i].exp_status, vecs[i].exp_ch, 1'b0);
            consume(vecs[i].name);
        end

        for (int r = 0; r < 4; r++) begin
            random_words(wa);
            cmd_r = WB'($urandom);
            model(wa, st_a, ch_a);
            start_frame(cmd_r, frame_bits(wa));
            finish_frame();
            check_bus($sformatf("rand%0d", r), cmd_r);
            check_data($sformatf("rand%0d", r), st_a, ch_a, 1'b0);
            consume($sformatf("rand%0d", r));
        end

        // Second frame with frame_ready low must be dropped and leave the first frame intact.
        random_words(wa); random_words(wb);
        model(wa, st_a, ch_a);
        start_frame(24'h0, frame_bits(wa));
        finish_frame();
        ovr_pulses = 0;
        start_frame(24'h0, frame_bits(wb));
        finish_frame();
        check("ovr_pulses", ovr_pulses, 1);
        check("ovr_count", 32'(overrun_count), 1);
        check_data("ovr_kept", st_a, ch_a, 1'b0);
        consume("ovr");

        // DRDY toggles and enable drop during SHIFT must neither abort nor queue a frame.
        random_words(wa);
        model(wa, st_a, ch_a);
        start_frame(24'h0, frame_bits(wa));
        n = 0;
        while (sclk_rises < 30 && n < 2000) begin @(negedge system_clock); n++; end
        check("t4_reach_bit30", 32'(sclk_rises >= 30), 1);
        enable = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drdy_n = 1'b1; repeat (5) @(negedge system_clock);
            drdy_n = 1'b0; repeat (5) @(negedge system_clock);
        end
        enable = 1'b1;
        finish_frame();
        repeat (20) @(negedge system_clock);
        check("t4_sclk_rises", sclk_rises, L);
        check("t4_cs_frames", cs_falls, 1);
        check_data("t4", st_a, ch_a, 1'b0);

        enable = 1'b0; busy_seen = 0; cs_falls = 0;
        @(negedge system_clock) drdy_n = 1'b0;
        repeat (30) @(negedge system_clock);
        drdy_n = 1'b1;
        repeat (5) @(negedge system_clock);
        check("t4_disabled_busy", busy_seen, 0);
        check("t4_disabled_cs", cs_falls, 0);
        enable = 1'b1;

        // Reset in the middle of SHIFT while the previous frame is still buffered.
        check("t5_pre_valid", 32'(frame_valid), 1);
        random_words(wa);
        start_frame(24'h0, frame_bits(wa));
        n = 0;
        while (sclk_rises < 50 && n < 2000) begin @(negedge system_clock); n++; end
        check("t5_reach_bit50", 32'(sclk_rises >= 50), 1);
        reset_n = 1'b0;
        drdy_n  = 1'b1;
        #1;
        check("t5_cs_n", 32'(spi_cs_n), 1);
        check("t5_sclk", 32'(spi_sclk), 0);
        check("t5_valid", 32'(frame_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_overrun_count", 32'(overrun_count), 0);
        repeat (2) @(negedge system_clock);
        reset_n = 1'b1;
        repeat (5) @(negedge system_clock);
        random_words(wa);
        cmd_r = WB'($urandom);
        model(wa, st_a, ch_a);
        start_frame(cmd_r, frame_bits(wa));
        finish_frame();
        check_bus("t5_after", cmd_r);
        check_data("t5_after", st_a, ch_a, 1'b0);
        consume("t5_after");

`ifdef ADS131_CRC_EN
        // CRC covers the original words; one channel bit is flipped on the wire.
        random_words(wa);
        wb = wa;
        wb[3][0] = ~wb[3][0];
        model(wb, st_b, ch_b);
        tx_bits = build_tx(wb);
        tx_bits[WB-1:0] = {crc16(build_tx(wa)), 8'h00};
        start_frame(24'h0, tx_bits);
        finish_frame();
        check("crc_bad_sclk", sclk_rises, L);
        check_data("crc_bad", st_b, ch_b, 1'b1);
        consume("crc_bad");
`endif

        // Saturation on the compact instance: 301 frames, never consumed.
        sat_timeouts = 0;
        for (int i = 0; i < 301; i++) begin
            @(negedge system_clock) s_drdy_n = 1'b0;
            n = 0;
            while (!s_busy && n < 20) begin @(negedge system_clock); n++; end
            if (!s_busy) sat_timeouts++;
            n = 0;
            while (s_busy && n < 400) begin @(negedge system_clock); n++; end
            if (s_busy) sat_timeouts++;
            s_drdy_n = 1'b1;
            repeat (3) @(negedge system_clock);
            if (i == 200) check("sat_count_200", 32'(s_overrun_count), 200);
        end
        check("sat_timeouts", sat_timeouts, 0);
        check("sat_count_final", 32'(s_overrun_count), 255);
        check("sat_valid", 32'(s_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ads131_frame_capture.md
Name: ads131_frame_capture

Overview:
- Per-sample data-frame engine for the ADS131A0x, downstream of the SPI init/reset controller.
- After ADC init completes, a falling edge on the ADC DRDY line starts one SPI frame: assert CS, drive SCLK, shift a command word out on MOSI, and capture the status word plus NUM_CH channel words from MISO.
- Captured samples are sign-extended to 32 bits and presented to the downstream DSP/FIFO through a single-entry valid/ready buffer.

Parameters:
- CLK_DIV, 6: SCLK half-period in system_clock cycles (50 MHz / 12 = 4.167 MHz).
- WORD_BITS, 24: device word length in bits.
- NUM_CH, 4: channel words per frame.
- CS_GUARD, 8: system_clock cycles CS stays high after a frame before a new DRDY is accepted.

Ports:
- system_clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  high once ADC init has completed; DRDY edges are ignored while low.
- drdy_n  in  1  ADC DRDY, asynchronous to system_clock.
- spi_sclk  out  1  SPI clock, CPOL=0.
- spi_cs_n  out  1  SPI chip select, active low.
- spi_mosi  out  1  SPI MOSI.
- spi_miso  in  1  SPI MISO.
- cmd_word  in  WORD_BITS  command sent in word 0; latched at frame start.
- frame_valid  out  1  captured frame available.
- frame_ready  in  1  consumer accepts the frame.
- status_word  out  16  upper 16 bits of MISO word 0.
- ch_data  out  32*NUM_CH  channel k occupies bits [32k+31:32k], sign-extended.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- overrun_count  out  8  saturating count of dropped frames.

Behaviour:
Reset values (applied immediately when reset_n falls, including mid-frame):
- spi_cs_n=1, spi_sclk=0, spi_mosi=0, frame_valid=0, status_word=0, ch_data=0, busy=0, overrun=0, overrun_count=0.
- State = IDLE; DRDY synchronizer flops reset to 1.

DRDY detection:
- drdy_n passes through a 2-flop synchronizer.
- A start event is a synchronized 1->0 edge with enable=1 in IDLE.
- Edges in any other state are ignored (not queued).

State machine:
- IDLE -> SETUP on a start event. cmd_word is latched and spi_cs_n drops on SETUP entry.
- SETUP: CLK_DIV cycles, SCLK low -> SHIFT.
- SHIFT: L = (NUM_CH+1)*WORD_BITS SCLK periods, each 2*CLK_DIV cycles, low half first.
  - MOSI changes on the SCLK rising edge; MISO is sampled on the SCLK falling edge (mode 1). All bits MSB-first.
  - The first MOSI bit is valid from SETUP entry.
  - MOSI carries cmd_word for word 0 and zeros for all later words.
- HOLD: CLK_DIV cycles with CS low and SCLK low, then spi_cs_n=1 -> STORE.
- STORE: 1 cycle. The buffer write is resolved here -> GUARD.
- GUARD: CS_GUARD cycles -> IDLE.

Capture:
- A shift register assembles each word.
- Word 0 bits [WORD_BITS-1:WORD_BITS-16] -> status_word.
- Word k (k≥1) -> channel k-1, sign-extended from bit WORD_BITS-1.

Output buffer (evaluated in STORE):
- If frame_valid=0, or frame_valid=1 and frame_ready=1 in the same cycle: load the new frame, frame_valid=1 next cycle.
- Otherwise: drop the new frame, keep the old data, pulse overrun, and increment overrun_count, saturating at 255.
- A handshake (frame_valid & frame_ready) outside STORE clears frame_valid next cycle.
- Outputs stay stable while frame_valid=1.

Timing:
- Latency from synchronized edge to spi_cs_n low: 1 cycle.
- Deasserting enable mid-frame does not abort the frame.

Optional Feature:
Macro ADS131_CRC_EN.
- Enabled:
  - Frame length is NUM_CH+2 words; the extra word is received CRC, carried in its upper 16 bits.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) is computed over all MISO bits of the status and channel words.
  - Output port crc_err (1 bit) is latched with the frame: 1 on mismatch, reset 0.
  - Frames are delivered regardless of crc_err.
- Disabled: frame length is NUM_CH+1 words and the crc_err port does not exist.

Test Plan:
1. Defaults, enable=1, drdy_n falls. MISO model returns status 0x2230xx, then 0x7FFFFF, 0x800000, 0x000001, 0xFFFFFF.
   -> Exactly 120 SCLK rising edges with CS low throughout.
   -> status_word=0x2230; ch_data = 0x007FFFFF, 0xFF800000, 0x00000001, 0xFFFFFFFF; frame_valid=1.
2. cmd_word=0x001100. -> MOSI sampled on falling edges reads 0x001100, followed by 96 zero bits; the first bit is stable before the first rising SCLK edge.
3. frame_ready=0, two DRDY frames. -> Second frame dropped, overrun pulses once, overrun_count=1, first-frame data unchanged. After 300 drops, overrun_count=255.
4. drdy_n toggles during SHIFT, and drdy_n falls with enable=0. -> No extra frame, SCLK count stays 120, busy stays 0 in the enable=0 case.
5. reset_n pulsed low at SHIFT bit 50. -> spi_cs_n=1, spi_sclk=0, frame_valid=0 immediately; the next DRDY yields a clean 120-bit frame with correct data.
6. ADS131_CRC_EN defined.
   -> Correct CRC word gives crc_err=0 and 144 SCLK edges.
   -> One flipped channel bit gives crc_err=1 and the frame is still delivered.
